// File: rtl/frq_div_pkg.sv
// Shared types and constants for the frequency-divider sweep scheduler.
package frq_div_pkg;

  localparam int SEL_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_SINGLE   = 2'b11;

endpackage

// File: rtl/frq_sweep_ctrl_if.sv
// Select-code handshake between the sweep scheduler and the divider's F_select input.
interface frq_sweep_ctrl_if
  import frq_div_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEFAULT
);
  logic [SEL_W-1:0] sel_out;
  logic             sel_valid;
  logic             sel_ready;

  modport master (output sel_out, output sel_valid, input sel_ready);
  modport slave  (input sel_out, input sel_valid, output sel_ready);
endinterface

// File: rtl/frq_dwell_timer.sv
// Dwell down-counter for the sweep scheduler.
// Optional tick prescaler enabled by defining FRQ_SWEEP_PRESCALE_EN; otherwise
// every clock cycle is a tick.
module frq_dwell_timer #(
  parameter int DWELL_W  = 16,
  parameter int PRESCALE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               tick_out,
  output logic               expire
);
  logic [DWELL_W-1:0] cnt;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("frq_dwell_timer: PRESCALE must be at least 1");
  end

`ifdef FRQ_SWEEP_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] ps_cnt;

  // Free-running prescaler, realigned on every accepted code so each dwell starts clean
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ps_cnt <= '0;
    else if (load || tick_out) ps_cnt <= '0;
    else                       ps_cnt <= ps_cnt + PS_W'(1);
  end

  assign tick_out = (ps_cnt == PS_W'(PRESCALE - 1));
`else
  assign tick_out = 1'b1;
`endif

  // Load max(value,1) on accept, then count down once per tick and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cnt <= '0;
    else if (load)                  cnt <= (value == '0) ? DWELL_W'(1) : value;
    else if (tick_out && cnt != '0) cnt <= cnt - DWELL_W'(1);
  end

  // Final tick of the dwell is the one seen while the count reads 1
  assign expire = (cnt == DWELL_W'(1));

endmodule

// File: rtl/frq_sweep_ctrl.sv
// Sweep scheduler: sole writer of the divider F_select code. Steps the code
// between lo_sel and hi_sel with a programmable dwell per code, handing each
// code over through a valid/ready handshake.
// Build option FRQ_SWEEP_PRESCALE_EN slows the dwell count by PRESCALE.
module frq_sweep_ctrl
  import frq_div_pkg::*;
#(
  parameter int SEL_W    = SEL_W_DEFAULT,
  parameter int DWELL_W  = 16,
  parameter int PRESCALE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    lo_sel,
  input  logic [SEL_W-1:0]    hi_sel,
  input  logic [DWELL_W-1:0]  dwell,
  frq_sweep_ctrl_if.master    sel_if,
  output logic                busy,
  output logic                step_tick,
  output logic                done,
  output logic                cfg_err
);
  state_e             state;
  logic [SEL_W-1:0]   sel_q, sel_nx, lo_q, hi_q;
  logic [1:0]         mode_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_up, dir_nx, last_code;
  logic               accept, tick, expire, dwell_end;

  assign accept    = sel_if.sel_valid && sel_if.sel_ready;
  assign dwell_end = (state == DWELL) && tick && expire;

  frq_dwell_timer #(
    .DWELL_W  (DWELL_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .value    (dwell_q),
    .tick_out (tick),
    .expire   (expire)
  );

  // Next code from the current one; ping-pong flips direction on a bound so the bound is not repeated
  always_comb begin
    sel_nx    = sel_q;
    dir_nx    = dir_up;
    last_code = 1'b0;
    case (mode_q)
      MODE_UP:   sel_nx = (sel_q == hi_q) ? lo_q : sel_q + SEL_W'(1);
      MODE_DOWN: sel_nx = (sel_q == lo_q) ? hi_q : sel_q - SEL_W'(1);
      MODE_PINGPONG: begin
        if (lo_q != hi_q) begin
          if (dir_up) begin
            if (sel_q == hi_q) begin dir_nx = 1'b0; sel_nx = sel_q - SEL_W'(1); end
            else sel_nx = sel_q + SEL_W'(1);
          end else begin
            if (sel_q == lo_q) begin dir_nx = 1'b1; sel_nx = sel_q + SEL_W'(1); end
            else sel_nx = sel_q - SEL_W'(1);
          end
        end
      end
      default: begin
        last_code = (sel_q == hi_q);
        if (!last_code) sel_nx = sel_q + SEL_W'(1);
      end
    endcase
  end

  // Sweep FSM, configuration latched at start, and the code register driving the divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= MODE_UP;
      dwell_q <= '0;
      dir_up  <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (lo_sel > hi_sel) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err <= 1'b0;
              mode_q  <= mode;
              lo_q    <= lo_sel;
              hi_q    <= hi_sel;
              dwell_q <= dwell;
              dir_up  <= 1'b1;
              sel_q   <= (mode == MODE_DOWN) ? hi_sel : lo_sel;
              state   <= OFFER;
            end
          end
        end
        OFFER: begin
          if (stop)                  state <= IDLE;
          else if (sel_if.sel_ready) state <= DWELL;
        end
        DWELL: begin
          if (stop) begin
            state <= IDLE;
          end else if (dwell_end) begin
            if (last_code) begin
              state <= DONE;
            end else begin
              sel_q  <= sel_nx;
              dir_up <= dir_nx;
              state  <= OFFER;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An abort suppresses the pulses of the cycle it lands in
  assign busy             = (state != IDLE);
  assign sel_if.sel_valid = (state == OFFER);
  assign sel_if.sel_out   = sel_q;
  assign step_tick        = dwell_end && !stop;
  assign done             = (state == DONE) && !stop;

endmodule
